// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: runs a req/ack handshake with variable-latency data memory,
// stalls upstream while an access is outstanding, and owns the MEM/WB pipeline register.
module mem_stage_ctrl #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 16,
  parameter int unsigned RW      = 4,
  parameter int unsigned OPW     = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           EXMEMmemRead,
  input  logic           EXMEMmemWrite,
  input  logic           EXMEMmemtoReg,
  input  logic           EXMEMRegWrite,
  input  logic [AW-1:0]  dataAddr,
  input  logic [DW-1:0]  wrDataOut,
  input  logic [RW-1:0]  rd_in,
  input  logic [OPW-1:0] EXMEMopcode,
  input  logic           MEMWBclear,
  output logic           mem_req,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic           mem_ack,
  input  logic [DW-1:0]  mem_rdata,
  output logic           memStall,
  output logic           MEMWBmemtoReg,
  output logic           MEMWBRegWrite,
  output logic [DW-1:0]  MEMWBaluOut,
  output logic [DW-1:0]  MEMWBmemData,
  output logic [RW-1:0]  MEMWBrd,
  output logic [OPW-1:0] MEMWBopcode,
  output logic           memErr
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           wb_memtoreg_q, wb_memtoreg_d;
  logic           wb_regwrite_q, wb_regwrite_d;
  logic [DW-1:0]  wb_alu_q, wb_alu_d;
  logic [DW-1:0]  wb_mem_q, wb_mem_d;
  logic [RW-1:0]  wb_rd_q, wb_rd_d;
  logic [OPW-1:0] wb_op_q, wb_op_d;

  logic           memop;
  logic           load_wb;
  logic [DW-1:0]  wb_data;

  assign memop = EXMEMmemRead | EXMEMmemWrite;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    load_wb     = 1'b0;
    wb_data     = '0;

    unique case (state_q)
      StIdle: begin
        if (memop) begin
          // A set write bit wins over read: the access is a store.
          mem_req_d   = 1'b1;
          mem_we_d    = EXMEMmemWrite;
          mem_addr_d  = dataAddr;
          mem_wdata_d = wrDataOut;
          cnt_d       = '0;
          state_d     = StAccess;
        end else begin
          load_wb = 1'b1;
        end
      end
      StAccess: begin
        if (mem_ack) begin
          rdata_d   = mem_we_q ? '0 : mem_rdata;
          mem_req_d = 1'b0;
          state_d   = StDone;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          rdata_d   = '0;
          mem_req_d = 1'b0;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        load_wb = 1'b1;
        wb_data = rdata_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load_wb && !MEMWBclear) begin
      wb_memtoreg_d = EXMEMmemtoReg;
      wb_regwrite_d = EXMEMRegWrite;
      wb_alu_d      = dataAddr;
      wb_mem_d      = wb_data;
      wb_rd_d       = rd_in;
      wb_op_d       = EXMEMopcode;
    end else begin
      wb_memtoreg_d = 1'b0;
      wb_regwrite_d = 1'b0;
      wb_alu_d      = '0;
      wb_mem_d      = '0;
      wb_rd_d       = '0;
      wb_op_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_alu_q      <= '0;
      wb_mem_q      <= '0;
      wb_rd_q       <= '0;
      wb_op_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_alu_q      <= wb_alu_d;
      wb_mem_q      <= wb_mem_d;
      wb_rd_q       <= wb_rd_d;
      wb_op_q       <= wb_op_d;
    end
  end

  // Stall covers the issuing IDLE cycle plus every ACCESS cycle.
  assign memStall = !reset && (((state_q == StIdle) && memop) || (state_q == StAccess));

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign memErr        = err_q;
  assign MEMWBmemtoReg = wb_memtoreg_q;
  assign MEMWBRegWrite = wb_regwrite_q;
  assign MEMWBaluOut   = wb_alu_q;
  assign MEMWBmemData  = wb_mem_q;
  assign MEMWBrd       = wb_rd_q;
  assign MEMWBopcode   = wb_op_q;

endmodule
